chart_sequencer: RTL and testbench

Playback controller for the step chart. Each chart entry holds a 4-bit arrow pattern and a 4-bit hold time in beats. This block sequences the chart read port through its `next_i` advance strobe and paces playback with an internal beat prescaler. It presents each non-empty arrow pattern to the judge/display logic over a valid/ready handshake. It sits between the chart ROM wrapper and the gameplay logic, and also rewinds the non-resettable chart address counter to entry 0 when a song is started.

---
 rtl/chart_sequencer.sv | 126 ++++++++++++
 tb/tb_chart_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Step-chart playback controller: walks the chart ROM through its advance strobe,
// paces each entry by a beat prescaler and hands arrow patterns out over valid/ready.
module chart_sequencer #(
  parameter int unsigned BEAT_DIV_P = 1000000,
  parameter int unsigned STEPS_P    = 128
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       pause_i,
  output logic       next_o,
  input  logic [3:0] arrows_i,
  input  logic [3:0] timing_i,
  output logic       note_valid_o,
  input  logic       note_ready_i,
  output logic [3:0] note_arrows_o,
  output logic [6:0] step_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned STEP_W  = 7;
  localparam int unsigned PRESC_W = $clog2(BEAT_DIV_P);
  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(STEPS_P - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BEAT_DIV_P - 1);

  typedef enum logic [2:0] {
    IDLE, REWIND, FETCH1, FETCH2, EMIT, WAIT, ADVANCE, DONE
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [3:0]         beats;

  // Every output is a register updated alongside the state transition that implies it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= IDLE;
      presc         <= '0;
      beats         <= '0;
      next_o        <= 1'b0;
      note_valid_o  <= 1'b0;
      note_arrows_o <= '0;
      step_o        <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      next_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            done_o <= 1'b0;
            busy_o <= 1'b1;
            if (step_o != '0) begin
              state  <= REWIND;
              next_o <= 1'b1;
            end else begin
              state <= FETCH1;
            end
          end
        end
        // Chart address counter has no reset of its own: clock it round to entry 0.
        REWIND: begin
          if (step_o == LAST_STEP) begin
            step_o <= '0;
            state  <= FETCH1;
          end else begin
            step_o <= step_o + STEP_W'(1);
            next_o <= 1'b1;
          end
        end
        FETCH1: state <= FETCH2;
        FETCH2: begin
          beats <= timing_i;
          presc <= '0;
          if (timing_i == 4'd0) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else if (arrows_i != 4'd0) begin
            state         <= EMIT;
            note_valid_o  <= 1'b1;
            note_arrows_o <= arrows_i;
          end else begin
            state <= WAIT;
          end
        end
        EMIT: begin
          if (note_ready_i) begin
            note_valid_o <= 1'b0;
            presc        <= '0;
            state        <= WAIT;
          end
        end
        // Beat counting; the last terminal count launches the advance strobe.
        WAIT: begin
          if (!pause_i) begin
            if (presc == PRESC_LAST) begin
              presc <= '0;
              beats <= beats - 4'd1;
              if (beats == 4'd1) begin
                state  <= ADVANCE;
                next_o <= 1'b1;
              end
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
        end
        ADVANCE: begin
          if (step_o == LAST_STEP) begin
            step_o <= '0;
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            step_o <= step_o + STEP_W'(1);
            state  <= FETCH1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: a per-cycle timeline model built from the playback
// rules, a counter-plus-synchronous-ROM chart, and literal checks that pin the model.
module tb_chart_sequencer;

  localparam int BEAT_DIV = 4;
  localparam int STEPS    = 128;
  localparam int MAXC     = 1024;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       start_i;
  logic       pause_i;
  logic       next_o;
  logic [3:0] arrows_q;
  logic [3:0] timing_q;
  logic       note_valid_o;
  logic       note_ready_i;
  logic [3:0] note_arrows_o;
  logic [6:0] step_o;
  logic       busy_o;
  logic       done_o;

  chart_sequencer #(.BEAT_DIV_P(BEAT_DIV), .STEPS_P(STEPS)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .pause_i(pause_i),
    .next_o(next_o), .arrows_i(arrows_q), .timing_i(timing_q),
    .note_valid_o(note_valid_o), .note_ready_i(note_ready_i),
    .note_arrows_o(note_arrows_o), .step_o(step_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Chart: address counter advanced by next_o, synchronous ROM read.
  logic [3:0] rom_a [STEPS];
  logic [3:0] rom_t [STEPS];
  logic [6:0] chart_addr;
  always_ff @(posedge clk or negedge reset_ni)
    if (!reset_ni) chart_addr <= '0;
    else if (next_o) chart_addr <= chart_addr + 7'd1;
  always_ff @(posedge clk) begin
    arrows_q <= rom_a[chart_addr];
    timing_q <= rom_t[chart_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_lo = -10, ready_hi = -20, pause_lo = -10, pause_hi = -20;
  int errors = 0, checks = 0;

  function automatic bit ready_at(int c);
    return !(c >= ready_lo && c <= ready_hi);
  endfunction
  function automatic bit pause_at(int c);
    return (c >= pause_lo && c <= pause_hi);
  endfunction

  always @(posedge clk) begin
    #1;
    note_ready_i = ready_at(cyc);
    pause_i      = pause_at(cyc);
  end

  // Expected per-cycle outputs; phase: 0 idle/done, 1 rewind, 2 fetch, 3 emit, 4 wait, 5 advance.
  int exp_next [MAXC], exp_valid [MAXC], exp_arrows [MAXC], exp_step [MAXC];
  int exp_busy [MAXC], exp_done [MAXC], exp_phase [MAXC];
  bit exp_known [MAXC];
  int dut_next [MAXC], dut_valid [MAXC], dut_arrows [MAXC], dut_step [MAXC];
  int dut_busy [MAXC], dut_done [MAXC];

  function automatic void put(int c, int nx, int vl, int ar, int st, int bs, int dn, int ph);
    if (c >= 0 && c < MAXC) begin
      exp_next[c] = nx; exp_valid[c] = vl; exp_arrows[c] = ar; exp_step[c] = st;
      exp_busy[c] = bs; exp_done[c] = dn; exp_phase[c] = ph; exp_known[c] = 1'b1;
    end
  endfunction

  function automatic void fill_idle(int c);
    for (int k = c; k < MAXC; k++) put(k, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Song timeline for a start request seen in cycle c0.
  function automatic void build(int c0);
    int c, step, arr, t, a, need;
    c = c0 + 1; step = exp_step[c0]; arr = exp_arrows[c0];
    if (step != 0) begin
      while (c < MAXC) begin
        put(c, 1, 0, arr, step, 1, 0, 1); c++;
        if (step == STEPS - 1) begin step = 0; break; end
        step++;
      end
    end
    while (c < MAXC) begin
      put(c, 0, 0, arr, step, 1, 0, 2); c++;
      put(c, 0, 0, arr, step, 1, 0, 2); c++;
      t = int'(rom_t[step]); a = int'(rom_a[step]);
      if (t == 0) break;
      if (a != 0) begin
        arr = a;
        while (c < MAXC) begin
          put(c, 0, 1, arr, step, 1, 0, 3); c++;
          if (ready_at(c - 1)) break;
        end
      end
      need = t * BEAT_DIV;
      while (need > 0 && c < MAXC) begin
        put(c, 0, 0, arr, step, 1, 0, 4);
        if (!pause_at(c)) need--;
        c++;
      end
      put(c, 1, 0, arr, step, 1, 0, 5); c++;
      if (step == STEPS - 1) begin step = 0; break; end
      step++;
    end
    for (int k = c; k < MAXC; k++) put(k, 0, 0, arr, step, 0, 1, 0);
  endfunction

  task automatic chk(input string name, input int c, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      dut_next[cyc] = int'(next_o); dut_valid[cyc] = int'(note_valid_o);
      dut_arrows[cyc] = int'(note_arrows_o); dut_step[cyc] = int'(step_o);
      dut_busy[cyc] = int'(busy_o); dut_done[cyc] = int'(done_o);
      if (exp_known[cyc]) begin
        chk("next", cyc, dut_next[cyc], exp_next[cyc]);
        chk("valid", cyc, dut_valid[cyc], exp_valid[cyc]);
        if (exp_valid[cyc] != 0) chk("arrows", cyc, dut_arrows[cyc], exp_arrows[cyc]);
        chk("step", cyc, dut_step[cyc], exp_step[cyc]);
        chk("busy", cyc, dut_busy[cyc], exp_busy[cyc]);
        chk("done", cyc, dut_done[cyc], exp_done[cyc]);
      end
    end
  end

  function automatic int sum_of(input int which, input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += (which == 0) ? dut_next[k] : dut_valid[k];
    return s;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r_lo, input int r_hi, input int p_lo, input int p_hi,
                          output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    if (r_lo >= 0) begin ready_lo = c0 + r_lo; ready_hi = c0 + r_hi; end
    else begin ready_lo = -10; ready_hi = -20; end
    if (p_lo >= 0) begin pause_lo = c0 + p_lo; pause_hi = c0 + p_hi; end
    else begin pause_lo = -10; pause_hi = -20; end
    start_i = 1'b1;
    build(c0);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  int s, r, t0, x, u;

  initial begin
    reset_ni = 1'b0; start_i = 1'b0; pause_i = 1'b0; note_ready_i = 1'b1;
    for (int i = 0; i < STEPS; i++) begin rom_a[i] = 4'h1; rom_t[i] = 4'd1; end
    rom_a[0] = 4'b0101; rom_t[0] = 4'd2;
    rom_a[1] = 4'b0000; rom_t[1] = 4'd1;
    rom_a[2] = 4'b1010; rom_t[2] = 4'd3;
    rom_a[3] = 4'b1100; rom_t[3] = 4'd0;
    fill_idle(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", cyc, int'(busy_o), 0);
    chk("reset_step", cyc, int'(step_o), 0);
    reset_ni = 1'b1;
    repeat (2) @(posedge clk);

    // Song 1: immediate ready, rest entry, pause mid-WAIT, start while busy, end marker.
    do_start(-1, -1, 27, 36, s);
    wait_until(s + 30);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_until(s + 52);
    chk("first_valid_lo", s + 2, dut_valid[s + 2], 0);
    chk("first_valid", s + 3, dut_valid[s + 3], 1);
    chk("first_arrows", s + 3, dut_arrows[s + 3], 5);
    chk("next_e0_early", s + 11, dut_next[s + 11], 0);
    chk("next_e0", s + 12, dut_next[s + 12], 1);
    chk("step_e0_hold", s + 12, dut_step[s + 12], 0);
    chk("step_e1", s + 13, dut_step[s + 13], 1);
    chk("rest_no_valid", s + 13, sum_of(1, s + 13, s + 19), 0);
    chk("next_rest_early", s + 18, dut_next[s + 18], 0);
    chk("next_rest", s + 19, dut_next[s + 19], 1);
    chk("next_nopause_slot", s + 35, dut_next[s + 35], 0);
    chk("next_paused", s + 45, dut_next[s + 45], 1);
    chk("done_early", s + 47, dut_done[s + 47], 0);
    chk("done", s + 48, dut_done[s + 48], 1);
    chk("done_busy", s + 48, dut_busy[s + 48], 0);
    chk("done_step", s + 48, dut_step[s + 48], 3);
    chk("done_no_next", s + 46, sum_of(0, s + 46, s + 51), 0);
    chk("model_next_e0", s + 12, exp_next[s + 12], 1);
    chk("model_next_paused", s + 45, exp_next[s + 45], 1);
    chk("model_valid", s + 3, exp_valid[s + 3], 1);

    // Song 2: rewind from step 3, first note held by back-pressure.
    do_start(128, 132, -1, -1, r);
    wait_until(r + 172);
    chk("rewind_count", r + 1, sum_of(0, r + 1, r + 125), 125);
    chk("rewind_last_step", r + 125, dut_step[r + 125], 127);
    chk("rewind_end_next", r + 126, dut_next[r + 126], 0);
    chk("rewind_wrap_step", r + 126, dut_step[r + 126], 0);
    chk("held_valid", r + 128, sum_of(1, r + 128, r + 133), 6);
    chk("held_arrows", r + 133, dut_arrows[r + 133], 5);
    chk("held_valid_drop", r + 134, dut_valid[r + 134], 0);
    chk("held_next_early", r + 141, dut_next[r + 141], 0);
    chk("held_next", r + 142, dut_next[r + 142], 1);
    chk("song2_done", r + 168, dut_done[r + 168], 1);
    chk("model_rewind_next", r + 125, exp_next[r + 125], 1);

    // Song 3: longer chart, asynchronous reset while waiting on step 5.
    rom_a[3] = 4'b0001; rom_t[3] = 4'd1;
    rom_a[4] = 4'b0000; rom_t[4] = 4'd1;
    rom_a[5] = 4'b0011; rom_t[5] = 4'd2;
    rom_a[6] = 4'b0000; rom_t[6] = 4'd0;
    do_start(-1, -1, -1, -1, t0);
    x = -1;
    for (int k = t0 + 1; k < MAXC; k++)
      if (x < 0 && exp_phase[k] == 4 && exp_step[k] == 5) x = k + 2;
    chk("reset_point_found", t0, int'(x > 0), 1);
    if (x < 0) x = t0 + 5;
    wait_until(x);
    @(negedge clk); #1;
    chk("pre_reset_step", x, dut_step[x], 5);
    chk("pre_reset_arrows", x, dut_arrows[x], 3);
    chk("pre_reset_busy", x, dut_busy[x], 1);
    reset_ni = 1'b0;
    fill_idle(cyc + 1);
    #1;
    chk("async_next", cyc, int'(next_o), 0);
    chk("async_valid", cyc, int'(note_valid_o), 0);
    chk("async_arrows", cyc, int'(note_arrows_o), 0);
    chk("async_step", cyc, int'(step_o), 0);
    chk("async_busy", cyc, int'(busy_o), 0);
    chk("async_done", cyc, int'(done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    repeat (3) @(posedge clk);

    // From IDLE at step 0: no rewind, first note three cycles after start.
    do_start(-1, -1, -1, -1, u);
    wait_until(u + 20);
    chk("idle_restart_valid", u + 3, dut_valid[u + 3], 1);
    chk("idle_restart_arrows", u + 3, dut_arrows[u + 3], 5);
    chk("idle_restart_no_rewind", u + 1, dut_next[u + 1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
